alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Control-side counterpart of the ALU output select mux. Accepts one ALU operation per start/ready handshake, decodes the opcode into the 2-bit output-select code (OSEL) that the result mux consumes, and produces the registered result and flags. Add/subtract and logical operations complete in a fixed two cycles. Shifts run one bit per cycle under a down-counter, so a shift by n finishes in 2+n cycles.

## Interface
- No parameters; datapath width fixed at 8 bits.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  operation request; accepted only in a cycle where READY=1.
- OPCODE  in  3  operation code, sampled at acceptance.
- A  in  8  operand A, sampled at acceptance.
- B  in  8  operand B, sampled at acceptance; B[2:0] is the shift amount for shifts.
- READY  out  1  high only in IDLE.
- OSEL  out  2  select code: 00 add/sub, 01 shift, 10 logical; 11 never driven.
- RESULT  out  8  registered result; held until the next completion.
- CARRY  out  1  carry / no-borrow / last bit shifted out.
- ZERO  out  1  RESULT == 0, updated with RESULT.
- DONE  out  1  one-cycle pulse when RESULT and flags update.

## Operation
- Opcodes:
  - 000 ADD: {CARRY,RESULT} = A+B, 9-bit sum.
  - 001 SUB: RESULT = A-B mod 256; CARRY = (A>=B), i.e. no borrow.
  - 010 SHL: logical shift left by B[2:0].
  - 011 SHR: logical shift right by B[2:0].
  - 100 AND, 101 OR, 110 XOR, 111 NOT A. All four force CARRY=0.
- OSEL mapping: OPCODE 00x→00; 01x→01; 1xx→10.
- States: IDLE, EXEC, SHIFT, DONE.
  - IDLE: READY=1. START=1 latches OPCODE, A and B, then moves to EXEC.
  - EXEC: OSEL updates to the decoded code.
    - Non-shift: result and flags are computed into staging registers; go to DONE.
    - Shift: the accumulator loads A, the counter loads B[2:0], and the shift-out bit clears to 0. Counter 0 goes to DONE; otherwise go to SHIFT.
  - SHIFT: each cycle shifts the accumulator one bit, captures the bit shifted out, and decrements the counter. When the counter reaches 0 after a shift, go to DONE.
  - DONE: RESULT, CARRY and ZERO load from staging; DONE=1 for this cycle only; return to IDLE.
- Shift CARRY is the bit shifted out in the final shift step (A[7-k] / A[k] chain). A shift amount of 0 gives RESULT=A and CARRY=0.
- B[7:3] is ignored for shifts.
- OSEL holds its value from EXEC until the next operation's EXEC.
- START is ignored when READY=0. No queueing; operands presented while busy are lost.

## Timing
- Reset values: READY=1, OSEL=00, RESULT=00, CARRY=0, ZERO=0, DONE=0; state IDLE; counter 0.
  - ZERO resets to 0 even though RESULT is 0. This is a deliberate exception; ZERO tracks RESULT only after the first completion.
- Cycle numbering: acceptance edge = cycle 0.
  - EXEC occupies cycle 1; OSEL is valid from cycle 1.
  - Non-shift ops: DONE and new RESULT are visible in cycle 2.
  - Shift by n (n=0..7): DONE in cycle 2+n.
- READY is low from cycle 1 through the DONE cycle and high again in the cycle after DONE.
  - Minimum issue interval: 3 cycles for non-shift ops, 3+n for shifts.
- RST asserted in any state takes priority over all else.
  - The next cycle shows reset values; any in-flight operation is discarded with no DONE pulse.
  - START asserted in the same cycle as RST is ignored.
- RESULT, CARRY and ZERO change only in the DONE cycle or on reset.

## Test plan
- Reset, then ADD A=F0 B=20 → cycle 1: OSEL=00. Cycle 2: DONE=1, RESULT=10, CARRY=1, ZERO=0. READY=1 in cycle 3.
- SUB A=05 B=05 → RESULT=00, CARRY=1, ZERO=1 in cycle 2.
- SUB A=03 B=05 → RESULT=FE, CARRY=0.
- SHL A=81 B=03 → OSEL=01 from cycle 1; DONE only in cycle 5; RESULT=08, CARRY=0.
- SHR A=81 B=01 → DONE in cycle 3; RESULT=40, CARRY=1.
- SHR A=81 B=F8 (amount 0) → DONE in cycle 2; RESULT=81, CARRY=0.
- XOR A=AA B=FF → OSEL=10; RESULT=55, CARRY=0, ZERO=0.
- NOT A=FF → RESULT=00, ZERO=1, OSEL=10.
- START held high continuously with changing operands during a SHL by 7 → only the first operation is accepted; exactly one DONE, in cycle 9. The next acceptance occurs in cycle 10.
- RST pulsed in cycle 3 of a SHL A=FF B=07 → no DONE pulse. Outputs show reset values (READY=1, OSEL=00, RESULT=00) from the cycle after RST. A following ADD 01+01 gives RESULT=02 with normal latency.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one 8-bit ALU op per start/ready handshake, drives the result-mux select and registered result/flags.
// Ports: clk_i, rst_i (sync, active-high); start_i/opcode_i/a_i/b_i request; ready_o high in IDLE;
// osel_o mux select (00 add/sub, 01 shift, 10 logical); result_o/carry_o/zero_o registered outputs; done_o one-cycle completion pulse.
module alu_op_sequencer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] opcode_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       ready_o,
  output logic [1:0] osel_o,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       zero_o,
  output logic       done_o
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, cnt_q, cnt_d;
  logic [7:0] a_q, b_q, acc_q, acc_d, res_q;
  logic [1:0] osel_q;
  logic carry_q, zero_q, shift_op, left, fin_load;
  logic [8:0] alu, step, fin;
  always_comb begin
    shift_op = op_q[2:1] == 2'b01;
    left = ~op_q[0];
    // {bit shifted out, shifted accumulator}
    step = left ? {acc_q, 1'b0} : {acc_q[0], 1'b0, acc_q[7:1]};
    case (op_q)
      3'b000:  alu = {1'b0, a_q} + {1'b0, b_q};
      3'b001:  alu = {a_q >= b_q, a_q - b_q};
      3'b100:  alu = {1'b0, a_q & b_q};
      3'b101:  alu = {1'b0, a_q | b_q};
      3'b110:  alu = {1'b0, a_q ^ b_q};
      default: alu = {1'b0, ~a_q};
    endcase
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    fin = step;
    fin_load = 1'b0;
    case (state_q)
      IDLE: state_d = start_i ? EXEC : IDLE;
      EXEC: begin
        acc_d = shift_op ? a_q : acc_q;
        cnt_d = shift_op ? b_q[2:0] : cnt_q;
        fin = shift_op ? {1'b0, a_q} : alu;
        fin_load = !shift_op || b_q[2:0] == 3'd0;
        state_d = fin_load ? DONE : SHIFT;
      end
      SHIFT: begin
        acc_d = step[7:0];
        cnt_d = cnt_q - 3'd1;
        fin_load = cnt_q == 3'd1;
        state_d = fin_load ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Result and flags load on the edge entering DONE so they appear together with the DONE pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      osel_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && start_i) begin
        op_q <= opcode_i;
        a_q <= a_i;
        b_q <= b_i;
        osel_q <= opcode_i[2] ? 2'b10 : {1'b0, opcode_i[1]};
      end
      if (fin_load) begin
        res_q <= fin[7:0];
        carry_q <= fin[8];
        zero_q <= fin[7:0] == 8'd0;
      end
    end
  end
  assign ready_o = state_q == IDLE;
  assign done_o = state_q == DONE;
  assign osel_o = osel_q;
  assign result_o = res_q;
  assign carry_o = carry_q;
  assign zero_o = zero_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] opcode = '0;
  logic [7:0] a = '0, b = '0;
  logic ready, carry, zero, done;
  logic [1:0] osel;
  logic [7:0] result;
  int n_cmp = 0, n_bad = 0;
  int m_res = 0, m_c = 0, m_z = 0, m_osel = 0;

  alu_op_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .opcode_i(opcode), .a_i(a), .b_i(b),
    .ready_o(ready), .osel_o(osel), .result_o(result), .carry_o(carry), .zero_o(zero), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns carry*256 + result from the operation definitions.
  function automatic int model(input int op, input int ai, input int bi);
    int n;
    n = bi % 8;
    case (op)
      0: return ai + bi;
      1: return (ai >= bi ? 256 : 0) + ((ai - bi) & 255);
      2: return ((ai << n) & 255) + (n != 0 ? ((ai >> (8 - n)) & 1) * 256 : 0);
      3: return (ai >> n) + (n != 0 ? ((ai >> (n - 1)) & 1) * 256 : 0);
      4: return ai & bi;
      5: return ai | bi;
      6: return ai ^ bi;
      default: return (~ai) & 255;
    endcase
  endfunction

  function automatic int osel_of(input int op);
    return op < 2 ? 0 : (op < 4 ? 1 : 2);
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_res"}, result, m_res);
    chk({tag, "_c"}, carry, m_c);
    chk({tag, "_z"}, zero, m_z);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_osel"}, osel, 0);
    chk({tag, "_done"}, done, 0);
    m_res = 0; m_c = 0; m_z = 0; m_osel = 0;
    check_regs(tag);
  endtask

  // Called at a negedge while idle; that cycle is cycle 0. Returns at the negedge of cycle lat+1.
  task automatic run_op(input int op, input int ai, input int bi);
    int r, lat;
    r = model(op, ai, bi);
    lat = 2 + ((op == 2 || op == 3) ? bi % 8 : 0);
    chk("ready_c0", ready, 1);
    start = 1'b1; opcode = 3'(op); a = 8'(ai); b = 8'(bi);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
        m_osel = osel_of(op);
        chk("osel_c1", osel, m_osel);
      end
      if (c < lat) begin
        chk("busy_done", done, 0);
        chk("busy_ready", ready, 0);
        chk("busy_res", result, m_res);
      end else if (c == lat) begin
        m_res = r & 255; m_c = r >> 8; m_z = (m_res == 0);
        chk("done_pulse", done, 1);
        chk("done_ready", ready, 0);
        chk("done_osel", osel, m_osel);
        check_regs("done");
      end else begin
        chk("after_ready", ready, 1);
        chk("after_done", done, 0);
        check_regs("after");
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");
    run_op(0, 'hF0, 'h20);
    run_op(1, 'h05, 'h05);
    run_op(1, 'h03, 'h05);
    run_op(2, 'h81, 'h03);
    run_op(3, 'h81, 'h01);
    run_op(3, 'h81, 'hF8);
    run_op(6, 'hAA, 'hFF);
    run_op(7, 'hFF, 'h00);
    run_op(4, 'hF0, 'h3C);
    run_op(5, 'h00, 'h00);
    run_op(0, 'hFF, 'h01);
    run_op(2, 'h01, 'h07);
    run_op(3, 'h80, 'h0F);
    // START held high through a SHL by 7; only the first request is taken.
    start = 1'b1; opcode = 3'd2; a = 8'hC3; b = 8'h07;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c < 9) begin
        chk("hold_busy_done", done, 0);
        opcode = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      end else if (c == 9) begin
        m_res = model(2, 'hC3, 7) & 255; m_c = model(2, 'hC3, 7) >> 8; m_z = (m_res == 0);
        chk("hold_done", done, 1);
        check_regs("hold");
      end else if (c == 10) begin
        chk("hold_ready10", ready, 1);
        chk("hold_done10", done, 0);
        opcode = 3'd0; a = 8'h12; b = 8'h34;
      end else if (c == 11) begin
        chk("hold_accept", ready, 0);
        chk("hold_osel", osel, 0);
        start = 1'b0;
      end else begin
        m_res = 'h46; m_c = 0; m_z = 0;
        chk("hold2_done", done, 1);
        check_regs("hold2");
      end
    end
    @(negedge clk);
    // Reset during cycle 3 of SHL FF by 7, with START also high then.
    start = 1'b1; opcode = 3'd2; a = 8'hFF; b = 8'h07;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        rst = 1'b1; start = 1'b1; opcode = 3'd0; a = 8'h55; b = 8'h01;
      end
      if (c == 4) begin
        rst = 1'b0; start = 1'b0;
        check_reset_vals("rst_mid");
      end
      if (c > 4) begin
        chk("rst_no_done", done, 0);
        chk("rst_idle", ready, 1);
      end
    end
    run_op(0, 'h01, 'h01);
    for (int i = 0; i < 60; i++)
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
